axi_line_fill: RTL

AXI4 read-burst line-fill engine that sits directly upstream of the cache's memory-side port. When the cache raises `miss`, the block fetches the missing line from memory with one INCR burst over the AXI4 read channels. It then streams each returned word into the cache's refill inputs (`mem_addr`, `mem_data_in`, `mem_wstb`, `mem_data_valid`, `mem_last`). Write-back is not covered: the cache is write-through/no-evict, so only the read channels are present.

---
 rtl/axi_line_fill.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/axi_line_fill.sv
// AXI4 read-burst line-fill engine.
// Fetches one cache line per miss and streams it into the cache refill port.
module axi_line_fill #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_SIZE_BITS = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    miss,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic [DATA_WIDTH/8-1:0] mem_wstb,
  output logic                    mem_data_valid,
  output logic                    mem_last,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    fill_err
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int BEATS = (1 << LINE_SIZE_BITS) / BPW;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SZ    = (BPW > 1) ? $clog2(BPW) : 0;

  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LMASK =
    ~(ADDR_WIDTH'((64'd1 << LINE_SIZE_BITS) - 64'd1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WAIT_CLR
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [ADDR_WIDTH-1:0]   r_line_base;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_data;
  logic [DATA_WIDTH/8-1:0] r_wstb;
  logic                    r_mem_valid;
  logic                    r_mem_last;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_err;

  logic                  w_beat;
  logic                  w_last;
  logic                  w_beat_err;
  logic [ADDR_WIDTH-1:0] w_beat_addr;

  assign w_beat      = r_rready && m_axi_rvalid;
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_beat_addr = r_line_base + (ADDR_WIDTH'(r_cnt) << SZ);
  // rlast must coincide exactly with the counted final beat
  assign w_beat_err  = (m_axi_rresp != 2'b00) || (m_axi_rlast != w_last);

  assign mem_addr       = r_mem_addr;
  assign mem_data_in    = r_mem_data;
  assign mem_wstb       = r_wstb;
  assign mem_data_valid = r_mem_valid;
  assign mem_last       = r_mem_last;
  assign m_axi_araddr   = r_line_base;
  assign m_axi_arlen    = 8'(BEATS - 1);
  assign m_axi_arsize   = 3'(SZ);
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arvalid  = r_arvalid;
  assign m_axi_rready   = r_rready;
  assign fill_err       = r_err;

  // Fill FSM: launch burst on miss, register refill beats, wait for miss to clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_line_base <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_wstb      <= '0;
      r_mem_valid <= 1'b0;
      r_mem_last  <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_valid <= 1'b0;
      r_mem_last  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (miss) begin
            r_line_base <= cpu_addr & LMASK;
            r_cnt       <= '0;
            r_arvalid   <= 1'b1;
            r_state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_mem_data  <= m_axi_rdata;
            r_mem_addr  <= w_beat_addr;
            r_wstb      <= '1;
            r_mem_valid <= 1'b1;
            r_mem_last  <= w_last;
            if (w_beat_err) r_err <= 1'b1;
            if (w_last) begin
              r_rready <= 1'b0;
              r_state  <= S_WAIT_CLR;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_WAIT_CLR: begin
          if (!miss) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
